// File: rtl/rgb2stream.sv
// rgb2stream: drains the frame reader's pixel FIFO and offset FIFO (both with a
// 1-cycle read latency) and emits one packet per burst on a 32-bit valid/ready
// stream: a header word {HDR_TAG, offset[23:0]}, BURST pixel words and an
// optional checksum trailer. When the reader reports its final burst and all
// pixels are gone, a single end-of-frame word {EOF_TAG, pixel_total[23:0]} is
// sent and the block parks until reset.
//
// Build option: define RGB2STREAM_CSUM_EN to append a 32-bit checksum word
// (sum of the packet's pixel words) carrying m_last. Without it, m_last marks
// the final pixel of each packet.
//
// The reader's "final" level input is named final_flag because "final" is a
// reserved word in SystemVerilog.
module rgb2stream #(
  parameter int         BURST   = 64,
  parameter logic [7:0] HDR_TAG = 8'hA5,
  parameter logic [7:0] EOF_TAG = 8'hEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] rgb_cnt,
  output logic        rgb_rd,
  input  logic [31:0] rgb_in,
  output logic        addr_rd,
  input  logic [31:0] addr_in,
  input  logic        final_flag,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy
);

  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PIX,
    S_CSUM,
    S_EOF,
    S_DONE
  } state_t;

  state_t         r_state;

  // FIFO read strobes and their one-cycle-later data-valid markers
  logic           r_rgb_rd;
  logic           r_addr_rd;
  logic           r_rd_p1;
  logic           r_addr_p1;

  logic [CW-1:0]  r_rd_cnt;     // pixel reads issued in this packet
  logic [CW-1:0]  r_beat;       // pixel words pushed in this packet
  logic [31:0]    r_total;      // pixel beats transferred since reset
  logic           r_tail_done;  // checksum / EOF word already pushed
`ifdef RGB2STREAM_CSUM_EN
  logic [31:0]    r_csum;
`endif

  // Two-entry skid buffer; entry 0 is the head that drives the stream
  logic [1:0]     r_sk_cnt;
  logic [31:0]    r_sk_data [0:1];
  logic           r_sk_last [0:1];
  logic           r_sk_pix  [0:1];

  logic           w_pop;
  logic           w_push;
  logic [31:0]    w_push_data;
  logic           w_push_last;
  logic           w_push_pix;
  logic           w_issue;
  logic [2:0]     w_free;
  logic [2:0]     w_inflight;
  logic           w_unused;

  assign m_valid  = (r_sk_cnt != 2'd0);
  assign m_data   = r_sk_data[0];
  assign m_last   = r_sk_last[0];
  assign rgb_rd   = r_rgb_rd;
  assign addr_rd  = r_addr_rd;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);

  // Offsets are below 2^24 and only the low 24 bits of the total are sent
  assign w_unused = ^{addr_in[31:24], r_total[31:24]};

  assign w_pop      = m_valid && m_ready;
  // Slots still free once this cycle's pop has happened, versus words already
  // requested from the pixel FIFO that will land in the skid
  assign w_free     = 3'd2 - {1'b0, r_sk_cnt} + {2'b00, w_pop};
  assign w_inflight = {2'b00, r_rgb_rd} + {2'b00, r_rd_p1};
  assign w_issue    = (r_state == S_PIX) && (r_rd_cnt < CW'(BURST)) &&
                      (w_free > w_inflight);

  // Select the word (if any) entering the skid buffer this cycle
  always_comb begin
    w_push      = 1'b0;
    w_push_data = 32'd0;
    w_push_last = 1'b0;
    w_push_pix  = 1'b0;
    case (r_state)
      S_HDR: begin
        if (r_addr_p1) begin
          w_push      = 1'b1;
          w_push_data = {HDR_TAG, addr_in[23:0]};
        end
      end
      S_PIX: begin
        if (r_rd_p1) begin
          w_push      = 1'b1;
          w_push_data = rgb_in;
          w_push_pix  = 1'b1;
`ifdef RGB2STREAM_CSUM_EN
          w_push_last = 1'b0;
`else
          w_push_last = (r_beat == CW'(BURST - 1));
`endif
        end
      end
`ifdef RGB2STREAM_CSUM_EN
      S_CSUM: begin
        if (!r_tail_done && ((r_sk_cnt != 2'd2) || w_pop)) begin
          w_push      = 1'b1;
          w_push_data = r_csum;
          w_push_last = 1'b1;
        end
      end
`endif
      S_EOF: begin
        if (!r_tail_done && (r_sk_cnt == 2'd0)) begin
          w_push      = 1'b1;
          w_push_data = {EOF_TAG, r_total[23:0]};
          w_push_last = 1'b1;
        end
      end
      default: begin
        w_push = 1'b0;
      end
    endcase
  end

  // Packet FSM, FIFO read pipeline, skid buffer and frame counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rgb_rd     <= 1'b0;
      r_addr_rd    <= 1'b0;
      r_rd_p1      <= 1'b0;
      r_addr_p1    <= 1'b0;
      r_rd_cnt     <= '0;
      r_beat       <= '0;
      r_total      <= 32'd0;
      r_tail_done  <= 1'b0;
`ifdef RGB2STREAM_CSUM_EN
      r_csum       <= 32'd0;
`endif
      r_sk_cnt     <= 2'd0;
      r_sk_data[0] <= 32'd0;
      r_sk_data[1] <= 32'd0;
      r_sk_last[0] <= 1'b0;
      r_sk_last[1] <= 1'b0;
      r_sk_pix[0]  <= 1'b0;
      r_sk_pix[1]  <= 1'b0;
    end else begin
      // read pipeline: strobe -> data valid one cycle later
      r_rgb_rd  <= w_issue;
      r_rd_p1   <= r_rgb_rd;
      r_addr_p1 <= r_addr_rd;
      if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + CW'(1);
      end

      // skid buffer: head at entry 0, shift on pop
      case ({w_push, w_pop})
        2'b10: begin
          r_sk_data[r_sk_cnt[0]] <= w_push_data;
          r_sk_last[r_sk_cnt[0]] <= w_push_last;
          r_sk_pix[r_sk_cnt[0]]  <= w_push_pix;
          r_sk_cnt               <= r_sk_cnt + 2'd1;
        end
        2'b01: begin
          r_sk_data[0] <= r_sk_data[1];
          r_sk_last[0] <= r_sk_last[1];
          r_sk_pix[0]  <= r_sk_pix[1];
          r_sk_cnt     <= r_sk_cnt - 2'd1;
        end
        2'b11: begin
          if (r_sk_cnt == 2'd1) begin
            r_sk_data[0] <= w_push_data;
            r_sk_last[0] <= w_push_last;
            r_sk_pix[0]  <= w_push_pix;
          end else begin
            r_sk_data[0] <= r_sk_data[1];
            r_sk_last[0] <= r_sk_last[1];
            r_sk_pix[0]  <= r_sk_pix[1];
            r_sk_data[1] <= w_push_data;
            r_sk_last[1] <= w_push_last;
            r_sk_pix[1]  <= w_push_pix;
          end
        end
        default: begin
        end
      endcase

      if (w_pop && r_sk_pix[0]) begin
        r_total <= r_total + 32'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_addr_rd   <= 1'b0;
          r_tail_done <= 1'b0;
          // a full burst wins over end-of-frame
          if (rgb_cnt >= 11'(BURST)) begin
            r_state   <= S_HDR;
            r_addr_rd <= 1'b1;
          end else if (final_flag && (rgb_cnt == 11'd0) && (r_sk_cnt == 2'd0)) begin
            r_state <= S_EOF;
          end
        end
        S_HDR: begin
          r_addr_rd <= 1'b0;
          r_rd_cnt  <= '0;
          r_beat    <= '0;
`ifdef RGB2STREAM_CSUM_EN
          r_csum    <= 32'd0;
`endif
          if (r_addr_p1) begin
            r_state <= S_PIX;
          end
        end
        S_PIX: begin
          if (r_rd_p1) begin
            r_beat <= r_beat + CW'(1);
`ifdef RGB2STREAM_CSUM_EN
            r_csum <= r_csum + rgb_in;
`endif
          end
          if (r_beat == CW'(BURST)) begin
`ifdef RGB2STREAM_CSUM_EN
            r_state <= S_CSUM;
`else
            if (r_sk_cnt == 2'd0) begin
              r_state <= S_IDLE;
            end
`endif
          end
        end
`ifdef RGB2STREAM_CSUM_EN
        S_CSUM: begin
          if (w_push) begin
            r_tail_done <= 1'b1;
          end
          if (r_tail_done && (r_sk_cnt == 2'd0)) begin
            r_state <= S_IDLE;
          end
        end
`endif
        S_EOF: begin
          if (w_push) begin
            r_tail_done <= 1'b1;
          end
          if (r_tail_done && w_pop) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_addr_rd <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2stream.sv
// tb_rgb2stream: directed bench for rgb2stream. Models the pixel and offset
// FIFOs with a 1-cycle read latency, records every stream transfer, and
// compares packets against hand-derived words.
module tb_rgb2stream;

  localparam int BURST = 64;
`ifdef RGB2STREAM_CSUM_EN
  localparam int PKT = BURST + 2;
  localparam logic LAST_ON_PIX = 1'b0;
`else
  localparam int PKT = BURST + 1;
  localparam logic LAST_ON_PIX = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] rgb_cnt;
  logic        rgb_rd;
  logic [31:0] rgb_in;
  logic        addr_rd;
  logic [31:0] addr_in;
  logic        final_flag;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        busy;

  always #5 clk = ~clk;

  rgb2stream #(.BURST(BURST), .HDR_TAG(8'hA5), .EOF_TAG(8'hEF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rgb_cnt    (rgb_cnt),
    .rgb_rd     (rgb_rd),
    .rgb_in     (rgb_in),
    .addr_rd    (addr_rd),
    .addr_in    (addr_in),
    .final_flag (final_flag),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy)
  );

  // FIFO model: stimulus appends to the queues, reads advance the pointers
  logic [31:0] pix_q[$];
  logic [31:0] addr_q[$];
  int          rd_ptr    = 0;
  int          ard       = 0;
  int          underflow = 0;

  always @(posedge clk) begin
    int nrd;
    nrd = rd_ptr;
    if (!rst_n) begin
      nrd = pix_q.size();
      ard <= addr_q.size();
    end else begin
      if (rgb_rd) begin
        if (nrd < pix_q.size()) begin
          rgb_in <= pix_q[nrd];
          nrd = nrd + 1;
        end else begin
          underflow <= underflow + 1;
        end
      end
      if (addr_rd) begin
        if (ard < addr_q.size()) begin
          addr_in <= addr_q[ard];
          ard <= ard + 1;
        end else begin
          underflow <= underflow + 1;
        end
      end
    end
    rd_ptr  <= nrd;
    rgb_cnt <= 11'(pix_q.size() - nrd);
  end

  // Stream monitor: capture transfers, track protocol invariants
  logic [32:0] cap_q[$];
  int          rd_total  = 0;
  int          ahead     = 0;
  int          ahead_err = 0;
  int          both_err  = 0;
  int          stab_err  = 0;
  int          pos       = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word  = '0;

  always @(posedge clk) begin
    int a;
    a = ahead;
    if (!rst_n) begin
      pos        <= 0;
      ahead      <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (rgb_rd) begin
        a = a + 1;
        rd_total <= rd_total + 1;
      end
      if (rgb_rd && addr_rd) both_err <= both_err + 1;
      if (prev_stall && (!m_valid || ({m_last, m_data} != prev_word)))
        stab_err <= stab_err + 1;
      prev_stall <= m_valid && !m_ready;
      prev_word  <= {m_last, m_data};
      if (m_valid && m_ready) begin
        cap_q.push_back({m_last, m_data});
        if (pos >= 1 && pos <= BURST) a = a - 1;
        pos <= m_last ? 0 : pos + 1;
      end
      if (a > 2) ahead_err <= ahead_err + 1;
      ahead <= a;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_pix(input int n, input logic [31:0] first, input logic [31:0] step);
    for (int i = 0; i < n; i++) pix_q.push_back(first + step * 32'(i));
  endtask

  task automatic run_until(input int target, input int rmode, input int final_at);
    int cyc;
    cyc = 0;
    while (cap_q.size() < target && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      m_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (final_at > 0 && cap_q.size() >= final_at) final_flag = 1'b1;
    end
    check_eq("words_by_deadline", 33'(cap_q.size() >= target), 33'd1);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    m_ready = 1'b1;
    @(negedge clk);
    while (busy && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("back_to_idle", 33'(busy), 33'd0);
  endtask

  task automatic check_pkt(input string tag, input int base, input logic [31:0] hdr, input int pb);
    logic [31:0] sum;
    sum = 32'd0;
    check_eq({tag, "_hdr"}, cap_q[base], {1'b0, hdr});
    for (int i = 0; i < BURST; i++) begin
      check_eq({tag, "_pix"}, cap_q[base + 1 + i],
               {LAST_ON_PIX && (i == BURST - 1), pix_q[pb + i]});
      sum = sum + pix_q[pb + i];
    end
`ifdef RGB2STREAM_CSUM_EN
    check_eq({tag, "_csum"}, cap_q[base + BURST + 1], {1'b1, sum});
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, pb, r0, c0, base2;
    logic s_v, s_rd, s_ard, s_busy;
    rst_n = 1'b0; m_ready = 1'b0; final_flag = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_m_valid", 33'(m_valid), 33'd0);
    check_eq("rst_m_last",  33'(m_last),  33'd0);
    check_eq("rst_m_data",  33'(m_data),  33'd0);
    check_eq("rst_rgb_rd",  33'(rgb_rd),  33'd0);
    check_eq("rst_addr_rd", 33'(addr_rd), 33'd0);
    check_eq("rst_busy",    33'(busy),    33'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic packet: offset 0x40, pixels 1..64, sink always ready
    m_ready = 1'b1;
    base = cap_q.size(); pb = pix_q.size();
    addr_q.push_back(32'h40);
    push_pix(64, 32'd1, 32'd1);
    @(negedge clk);                       // FIFO count now visible
    @(negedge clk);
    check_eq("lat_addr_rd", 33'(addr_rd), 33'd1);
    check_eq("lat_busy",    33'(busy),    33'd1);
    @(negedge clk);
    check_eq("lat_valid_early", 33'(m_valid), 33'd0);
    @(negedge clk);
    check_eq("lat_valid", 33'(m_valid), 33'd1);
    check_eq("lat_hdr",   33'(m_data),  33'h0A5000040);
    run_until(base + PKT, 0, 0);
    check_eq("basic_hdr",   cap_q[base],      {1'b0, 32'hA5000040});
    check_eq("basic_pix64", cap_q[base + 64], {LAST_ON_PIX, 32'd64});
`ifdef RGB2STREAM_CSUM_EN
    check_eq("basic_csum",  cap_q[base + 65], {1'b1, 32'h00000820});
`endif
    check_pkt("basic", base, 32'hA5000040, pb);
    wait_idle();
    check_eq("basic_beats", 33'(cap_q.size() - base), 33'(PKT));

    // Sink ready one cycle in three; offset upper byte must be dropped
    base = cap_q.size(); pb = pix_q.size();
    addr_q.push_back(32'hFF001234);
    push_pix(64, 32'h10000000, 32'h01010101);
    run_until(base + PKT, 1, 0);
    check_pkt("toggle", base, 32'hA5001234, pb);
    wait_idle();
    check_eq("toggle_beats",  33'(cap_q.size() - base), 33'(PKT));
    check_eq("toggle_stable", 33'(stab_err),  33'd0);
    check_eq("toggle_ahead",  33'(ahead_err), 33'd0);

    // One word short of a burst: nothing may start
    base = cap_q.size(); pb = pix_q.size();
    addr_q.push_back(32'h200);
    push_pix(63, 32'hFFFFFFF0, 32'd1);
    s_v = 1'b0; s_rd = 1'b0; s_ard = 1'b0; s_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      s_v = s_v | m_valid; s_rd = s_rd | rgb_rd; s_ard = s_ard | addr_rd; s_busy = s_busy | busy;
    end
    check_eq("short_valid",   33'(s_v),    33'd0);
    check_eq("short_rgb_rd",  33'(s_rd),   33'd0);
    check_eq("short_addr_rd", 33'(s_ard),  33'd0);
    check_eq("short_busy",    33'(s_busy), 33'd0);
    push_pix(1, 32'h0000002F, 32'd1);     // exactly BURST now
    run_until(base + PKT, 0, 0);
    check_pkt("exact", base, 32'hA5000200, pb);
    wait_idle();

    // Sink stalled: header plus one pixel held, no more reads
    m_ready = 1'b0;
    base = cap_q.size(); pb = pix_q.size(); r0 = rd_total;
    addr_q.push_back(32'h003ABCDE);
    push_pix(64, 32'h80000000, 32'd3);
    repeat (30) @(negedge clk);
    check_eq("stall_valid",  33'(m_valid), 33'd1);
    check_eq("stall_word",   {m_last, m_data}, {1'b0, 32'hA53ABCDE});
    check_eq("stall_rgb_rd", 33'(rgb_rd), 33'd0);
    check_eq("stall_reads",  33'(rd_total - r0), 33'd1);
    run_until(base + PKT, 0, 0);
    check_pkt("stall", base, 32'hA53ABCDE, pb);
    wait_idle();
    check_eq("stall_stable", 33'(stab_err), 33'd0);

    // Reset in the middle of a packet, then a fresh packet
    base = cap_q.size();
    addr_q.push_back(32'h77);
    push_pix(64, 32'h500, 32'd1);
    run_until(base + 21, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid",  33'(m_valid), 33'd0);
    check_eq("midrst_busy",   33'(busy),    33'd0);
    check_eq("midrst_rgb_rd", 33'(rgb_rd),  33'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base2 = cap_q.size(); pb = pix_q.size();
    addr_q.push_back(32'h00ABCDEF);
    push_pix(64, 32'hC0DE0000, 32'd7);
    run_until(base2 + PKT, 0, 0);
    check_pkt("fresh", base2, 32'hA5ABCDEF, pb);
    wait_idle();

    // final raised during pixel beat 30: packet completes, then EOF
    base = cap_q.size(); pb = pix_q.size();
    addr_q.push_back(32'h100);
    push_pix(64, 32'h20, 32'd2);
    run_until(base + PKT + 1, 0, base + 31);
    check_pkt("final", base, 32'hA5000100, pb);
    check_eq("eof_word", cap_q[base + PKT], {1'b1, 32'hEF000080});
    repeat (5) @(negedge clk);
    check_eq("done_busy",  33'(busy),    33'd0);
    check_eq("done_valid", 33'(m_valid), 33'd0);

    // Terminal state ignores a full FIFO
    c0 = cap_q.size(); r0 = rd_total;
    addr_q.push_back(32'h5);
    push_pix(64, 32'd1, 32'd1);
    repeat (60) @(negedge clk);
    check_eq("done_no_words", 33'(cap_q.size() - c0), 33'd0);
    check_eq("done_no_reads", 33'(rd_total - r0), 33'd0);
    check_eq("done_no_addr",  33'(addr_q.size() - ard), 33'd1);
    check_eq("done_busy2",    33'(busy), 33'd0);

    check_eq("rd_and_addr_rd", 33'(both_err),  33'd0);
    check_eq("fifo_underflow", 33'(underflow), 33'd0);
    check_eq("reads_ahead",    33'(ahead_err), 33'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
